// File: rtl/gpr_bank.sv
// Parametrised register bank: byte-lane writes, masked registered reads, busy scoreboard.
// Define GPR_BANK_BYPASS_EN to forward same-cycle write data into a read of the same register.
module gpr_bank #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8,
    parameter int NRD    = 2,
    parameter int LANES  = DATA_W / 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NRD-1:0]          rd_en,
    input  logic [NRD*ADDR_W-1:0]   rd_addr,
    input  logic [NRD*LANES-1:0]    rd_lane_mask,
    output logic [NRD*DATA_W-1:0]   rd_data,
    input  logic [LANES-1:0]        wr_be,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [DATA_W-1:0]       wr_data,
    input  logic                    sb_set,
    input  logic [ADDR_W-1:0]       sb_addr,
    output logic [DEPTH-1:0]        busy
);

    logic [DATA_W-1:0]     gpr_q [DEPTH];
    logic [DATA_W-1:0]     gpr_d [DEPTH];
    logic [DATA_W-1:0]     rd_src [NRD];
    logic [NRD*DATA_W-1:0] rd_data_q, rd_data_d;
    logic [DEPTH-1:0]      busy_q, busy_d;

    always_comb begin
        for (int r = 0; r < DEPTH; r++) begin
            gpr_d[r] = gpr_q[r];
        end
        for (int k = 0; k < LANES; k++) begin
            if (wr_be[k]) begin
                gpr_d[wr_addr][8*k +: 8] = wr_data[8*k +: 8];
            end
        end
    end

    // gpr_d differs from gpr_q only in the lanes being written, so reading it
    // yields exactly the per-lane merge needed for forwarding.
    always_comb begin
        for (int p = 0; p < NRD; p++) begin
`ifdef GPR_BANK_BYPASS_EN
            rd_src[p] = gpr_d[rd_addr[p*ADDR_W +: ADDR_W]];
`else
            rd_src[p] = gpr_q[rd_addr[p*ADDR_W +: ADDR_W]];
`endif
        end
    end

    always_comb begin
        rd_data_d = rd_data_q;
        for (int p = 0; p < NRD; p++) begin
            if (rd_en[p]) begin
                for (int k = 0; k < LANES; k++) begin
                    rd_data_d[p*DATA_W + 8*k +: 8] =
                        rd_lane_mask[p*LANES + k] ? rd_src[p][8*k +: 8] : 8'h00;
                end
            end
        end
    end

    // Set is applied after clear so a new producer wins over a retiring one.
    always_comb begin
        busy_d = busy_q;
        if (wr_be != '0) begin
            busy_d[wr_addr] = 1'b0;
        end
        if (sb_set) begin
            busy_d[sb_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < DEPTH; r++) begin
                gpr_q[r] <= '0;
            end
            rd_data_q <= '0;
            busy_q    <= '0;
        end else begin
            for (int r = 0; r < DEPTH; r++) begin
                gpr_q[r] <= gpr_d[r];
            end
            rd_data_q <= rd_data_d;
            busy_q    <= busy_d;
        end
    end

    assign rd_data = rd_data_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_gpr_bank.sv
// Directed bench for gpr_bank with a behavioural reference model checked every cycle.
// Handshake: none; inputs change 2ns after the rising edge, outputs are checked on the falling edge.
module tb_gpr_bank;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 8;
    localparam int NRD    = 2;
    localparam int LANES  = 2;
    localparam int ADDR_W = 3;

    logic                  clk;
    logic                  rst;
    logic [NRD-1:0]        rd_en;
    logic [NRD*ADDR_W-1:0] rd_addr;
    logic [NRD*LANES-1:0]  rd_lane_mask;
    logic [NRD*DATA_W-1:0] rd_data;
    logic [LANES-1:0]      wr_be;
    logic [ADDR_W-1:0]     wr_addr;
    logic [DATA_W-1:0]     wr_data;
    logic                  sb_set;
    logic [ADDR_W-1:0]     sb_addr;
    logic [DEPTH-1:0]      busy;

    int n_checks = 0;
    int n_fail   = 0;
    logic [DATA_W-1:0] exp_bypass;

    gpr_bank #(.DATA_W(DATA_W), .DEPTH(DEPTH), .NRD(NRD)) dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_lane_mask(rd_lane_mask), .rd_data(rd_data), .wr_be(wr_be),
        .wr_addr(wr_addr), .wr_data(wr_data), .sb_set(sb_set),
        .sb_addr(sb_addr), .busy(busy)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    logic [DATA_W-1:0] m_gpr [DEPTH];
    logic [DATA_W-1:0] m_old [DEPTH];
    logic [DATA_W-1:0] m_rd  [NRD];
    logic [DEPTH-1:0]  m_busy;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < DEPTH; r++) m_gpr[r] = '0;
            for (int p = 0; p < NRD; p++) m_rd[p] = '0;
            m_busy = '0;
        end else begin
            m_old = m_gpr;
            for (int k = 0; k < LANES; k++)
                if (wr_be[k]) m_gpr[wr_addr][8*k +: 8] = wr_data[8*k +: 8];
            for (int p = 0; p < NRD; p++) begin
                if (rd_en[p]) begin
                    logic [DATA_W-1:0] word;
`ifdef GPR_BANK_BYPASS_EN
                    word = m_gpr[rd_addr[p*ADDR_W +: ADDR_W]];
`else
                    word = m_old[rd_addr[p*ADDR_W +: ADDR_W]];
`endif
                    for (int k = 0; k < LANES; k++)
                        m_rd[p][8*k +: 8] = rd_lane_mask[p*LANES + k] ? word[8*k +: 8] : 8'h00;
                end
            end
            if (wr_be != 0) m_busy[wr_addr] = 1'b0;
            if (sb_set) m_busy[sb_addr] = 1'b1;
        end
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            for (int p = 0; p < NRD; p++)
                check($sformatf("model rd_data[%0d]", p), 32'(rd_data[p*DATA_W +: DATA_W]), 32'(m_rd[p]));
            check("model busy", 32'(busy), 32'(m_busy));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle();
        rd_en = '0; rd_addr = '0; rd_lane_mask = '0;
        wr_be = '0; wr_addr = '0; wr_data = '0;
        sb_set = 1'b0; sb_addr = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_rd(input int p, input int addr, input logic [LANES-1:0] mask);
        rd_en[p] = 1'b1;
        rd_addr[p*ADDR_W +: ADDR_W] = ADDR_W'(addr);
        rd_lane_mask[p*LANES +: LANES] = mask;
    endtask

    task automatic set_wr(input int addr, input logic [DATA_W-1:0] data, input logic [LANES-1:0] be);
        wr_addr = ADDR_W'(addr);
        wr_data = data;
        wr_be = be;
    endtask

    function automatic logic [DATA_W-1:0] port(input int p);
        return rd_data[p*DATA_W +: DATA_W];
    endfunction

    // ---------------- directed sequence ----------------
    initial begin
        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        // all registers read zero after reset
        for (int a = 0; a < DEPTH; a++) begin
            idle(); set_rd(0, a, 2'b11); set_rd(1, a, 2'b11);
            step();
            check("reset read p0", 32'(port(0)), 32'h0);
            check("reset read p1", 32'(port(1)), 32'h0);
        end
        check("reset busy", 32'(busy), 32'h0);

        // partial-lane overwrite
        idle(); set_wr(3, 16'hA5C3, 2'b11); step();
        idle(); set_wr(3, 16'h00FF, 2'b10); step();
        idle(); set_rd(0, 3, 2'b11); step();
        check("lane write r3", 32'(port(0)), 32'h00C3);

        // lane masking on two ports reading the same register
        idle(); set_wr(5, 16'h1234, 2'b11); step();
        idle(); set_rd(0, 5, 2'b01); set_rd(1, 5, 2'b10); step();
        check("mask p0 r5", 32'(port(0)), 32'h0034);
        check("mask p1 r5", 32'(port(1)), 32'h1200);
        idle(); set_rd(0, 5, 2'b00); step();
        check("mask zero r5", 32'(port(0)), 32'h0000);
        check("hold p1 r5", 32'(port(1)), 32'h1200);

        // same-cycle read/write
        idle(); set_wr(2, 16'h1111, 2'b11); step();
        idle(); set_wr(2, 16'hBEEF, 2'b11); set_rd(0, 2, 2'b11); step();
`ifdef GPR_BANK_BYPASS_EN
        exp_bypass = 16'hBEEF;
`else
        exp_bypass = 16'h1111;
`endif
        check("same-cycle r2", 32'(port(0)), 32'(exp_bypass));
        idle(); set_rd(0, 2, 2'b11); step();
        check("next-cycle r2", 32'(port(0)), 32'hBEEF);
        idle(); step();
        check("hold r2", 32'(port(0)), 32'hBEEF);

        // scoreboard
        idle(); sb_set = 1'b1; sb_addr = 3'd6; step();
        check("busy set r6", 32'(busy[6]), 32'h1);
        idle(); sb_set = 1'b1; sb_addr = 3'd6; set_wr(6, 16'h7777, 2'b11); step();
        check("busy set+clr r6", 32'(busy[6]), 32'h1);
        idle(); set_wr(6, 16'h8888, 2'b11); step();
        check("busy clr r6", 32'(busy[6]), 32'h0);
        idle(); sb_set = 1'b1; sb_addr = 3'd7; step();
        idle(); sb_set = 1'b1; sb_addr = 3'd0; set_wr(7, 16'h0042, 2'b01); step();
        check("busy set r0", 32'(busy), 32'h01);

        // mixed stimulus, checked by the model every cycle
        for (int i = 0; i < 60; i++) begin
            idle();
            rd_en = NRD'($urandom_range(0, 3));
            rd_addr = NRD*ADDR_W'($urandom_range(0, 63));
            rd_lane_mask = NRD*LANES'($urandom_range(0, 15));
            wr_be = LANES'($urandom_range(0, 3));
            wr_addr = ADDR_W'($urandom_range(0, 7));
            wr_data = DATA_W'($urandom_range(0, 65535));
            sb_set = 1'($urandom_range(0, 1));
            sb_addr = ADDR_W'($urandom_range(0, 7));
            step();
        end

        // asynchronous reset in the middle of a write/read cycle
        idle(); sb_set = 1'b1; sb_addr = 3'd4; set_wr(1, 16'h5A5A, 2'b11); set_rd(0, 1, 2'b11); step();
        idle(); set_rd(0, 1, 2'b11); set_rd(1, 4, 2'b11); set_wr(1, 16'hFFFF, 2'b11);
        #1 rst = 1'b1;
        #1;
        check("async rst rd_data", rd_data, 32'h0);
        check("async rst busy", 32'(busy), 32'h0);
        step();
        idle(); rst = 1'b0;
        set_rd(0, 1, 2'b11); step();
        check("post-rst r1", 32'(port(0)), 32'h0);

        idle(); step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gpr_bank.md
# gpr_bank

Parametrised general-purpose register bank for the pipeline's decode/writeback stages. It generalises the 8×16 two-read-port register file to configurable width, depth and read-port count. It supports per-byte-lane writes and per-lane read masking, with registered read data. A per-register busy scoreboard lets decode detect pending writebacks.

## Interface
Parameters:
- DATA_W, 16, register width in bits; must be a multiple of 8.
- DEPTH, 8, number of registers; power of two, ≥2.
- NRD, 2, number of read ports.
- LANES, DATA_W/8, derived; byte lanes per register.
- ADDR_W, $clog2(DEPTH), derived; address width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- rd_en  in  NRD  per-port read enable.
- rd_addr  in  NRD*ADDR_W  per-port read address; port p at [p*ADDR_W +: ADDR_W].
- rd_lane_mask  in  NRD*LANES  per-port lane enable; a 0 bit returns zero in that byte.
- rd_data  out  NRD*DATA_W  registered read data, port p at [p*DATA_W +: DATA_W].
- wr_be  in  LANES  byte-lane write enables; all-zero means no write.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data; lane k = wr_data[8k+7:8k].
- sb_set  in  1  mark register sb_addr busy (producer issued).
- sb_addr  in  ADDR_W  scoreboard set address.
- busy  out  DEPTH  per-register pending-write flags.

## Operation
- Storage: DEPTH×DATA_W flops.
- Write: each lane k with wr_be[k]=1 updates gpr[wr_addr][8k+7:8k]. Other lanes hold their value.
- Read: when rd_en[p]=1, rd_data[p] loads gpr[rd_addr[p]] with lanes masked by rd_lane_mask[p]. A masked lane (bit 0) loads 8'h00. rd_lane_mask=all-zero yields 0.
- Read hold: when rd_en[p]=0, rd_data[p] holds its previous value.
- Multiple read ports may address the same register; each port is independent.
- Scoreboard clear: any write (wr_be≠0) clears busy[wr_addr], including partial-lane writes.
- Scoreboard set: sb_set=1 sets busy[sb_addr].
- Simultaneous set and clear on the same address: set wins, so busy stays 1 (a new producer has issued).
- Different addresses: set and clear both take effect in the same cycle.
- sb_set to an already busy register leaves it busy. No counting; one outstanding producer per register.
- Reset (any time, including mid-write): all gpr=0, all rd_data=0, busy=0. Takes effect immediately and asynchronously. The first write after reset deassertion lands on the first rising edge.

## Timing
- Write latency: data is in the array after the rising edge where wr_be≠0.
- Read latency: 1 cycle. Address is sampled at edge N, rd_data valid after edge N and stable through edge N+1.
- Same-cycle read/write to the same address is governed by the GPR_BANK_BYPASS_EN macro (see Configuration).
- Read in the cycle after a write always returns the new data.
- busy updates 1 cycle after sb_set/write. A decode stage sampling busy sees the set at edge N+1.
- No combinational path from any input to any output.

## Configuration
- Macro: GPR_BANK_BYPASS_EN.
- Defined: same-cycle write forwarding is enabled. If rd_addr[p]==wr_addr with rd_en[p]=1 and wr_be≠0, rd_data[p] receives a per-lane merge. Lanes with wr_be=1 take wr_data; other lanes take old contents. rd_lane_mask is applied after the merge.
- Undefined: no forwarding. A same-cycle read returns the pre-write contents, and the new data is visible one cycle later.
- Scoreboard behaviour is identical in both builds.

## Test plan
- Reset, then read all addresses on both ports with mask all-ones → rd_data=0 on every read; busy=0.
- Write 16'hA5C3 to r3 with wr_be=2'b11. Next cycle write 16'h00FF with wr_be=2'b10. Then read r3 → 16'h00C3.
- Write 16'h1234 to r5. Read r5 on port 0 with mask 2'b01 and on port 1 with mask 2'b10, same cycle → port 0 =16'h0034, port 1 =16'h1200.
- r2 holds 16'h1111. Write 16'hBEEF to r2 and read r2 in the same cycle:
  - With GPR_BANK_BYPASS_EN: result 16'hBEEF.
  - Without GPR_BANK_BYPASS_EN: result 16'h1111, then 16'hBEEF the next cycle.
- sb_set r6 → busy[6]=1. Next cycle, sb_set r6 plus a write to r6 → busy[6] stays 1. Next cycle, write r6 only → busy[6]=0.
- Assert rst mid-cycle while rd_en=1 and wr_be=2'b11 to r1 → outputs go to 0 immediately. After release, r1 reads 0.
